load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/mips_pkg.sv | 39 +++
 rtl/load_store_unit_if.sv | 36 +++
 rtl/load_extend.sv | 18 +
 rtl/load_store_unit.sv | 90 +++++++++
 tb/tb_load_store_unit.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states,
// and the latched request record.
package mips_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  size;
        logic        sign;
        logic        we;
    } lsu_req_t;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_HALF: return 3'd2;
            SZ_WORD: return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_HALF: return ~a[0];
            SZ_WORD: return a == 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline request/response and byte-wide data-memory signals of the LSU.
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              MemoryRead;
    logic              MemoryWrite;
    logic [ADDR_W-1:0] ALUResult;
    logic [31:0]       write_data;
    logic [1:0]        mem_size;
    logic              load_signed;
    logic              stall;
    logic [31:0]       load_data;
    logic              load_valid;
    logic              fault;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              mem_ready;

    // slave: the LSU itself; master: pipeline plus memory around it
    modport slave (
        input  MemoryRead, MemoryWrite, ALUResult, write_data, mem_size, load_signed,
        output stall, load_data, load_valid, fault,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport master (
        output MemoryRead, MemoryWrite, ALUResult, write_data, mem_size, load_signed,
        input  stall, load_data, load_valid, fault,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/load_extend.sv
// Sign/zero extension of the assembled load bytes to 32 bits.
module load_extend
    import mips_pkg::*;
(
    input  logic [31:0] asm_data,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] load_data
);
    always_comb begin
        load_data = asm_data;
        case (size)
            SZ_BYTE: load_data = {{24{sign_ext & asm_data[7]}}, asm_data[7:0]};
            SZ_HALF: load_data = {{16{sign_ext & asm_data[15]}}, asm_data[15:0]};
            default: load_data = asm_data;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Serialises byte/half/word loads and stores onto a byte-wide memory port,
// big-endian, with a one-cycle DONE state that reports load results.
module load_store_unit
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input logic clk,
    input logic rst,
    load_store_unit_if.slave bus
);
    state_t            state;
    lsu_req_t          req_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       asm_q;
    logic [31:0]       ext_data;
    logic [2:0]        cnt;
    logic [2:0]        last_idx;
    logic [1:0]        byte_sel;
    logic              req_any;
    logic              req_ok;

    always_comb begin
        req_any = bus.MemoryRead | bus.MemoryWrite;
        req_ok  = (bus.MemoryRead ^ bus.MemoryWrite) && (bus.mem_size != SZ_RSVD) &&
                  is_aligned(bus.mem_size, bus.ALUResult[1:0]);
    end

    // Byte 0 of the access is the most significant one of the store data.
    always_comb begin
        last_idx = size_bytes(req_q.size) - 3'd1;
        byte_sel = 2'(last_idx - cnt);
        case (byte_sel)
            2'd0:    bus.mem_wdata = req_q.data[7:0];
            2'd1:    bus.mem_wdata = req_q.data[15:8];
            2'd2:    bus.mem_wdata = req_q.data[23:16];
            default: bus.mem_wdata = req_q.data[31:24];
        endcase
        bus.stall      = (state == IDLE && req_ok) || state == ACCESS;
        bus.fault      = state == IDLE && req_any && !req_ok;
        bus.mem_req    = state == ACCESS;
        bus.mem_we     = state == ACCESS && req_q.we;
        bus.mem_addr   = addr_q + ADDR_W'(cnt);
        bus.load_valid = state == DONE && !req_q.we;
        bus.load_data  = ext_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            req_q  <= '0;
            addr_q <= '0;
            asm_q  <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_ok) begin
                        addr_q     <= bus.ALUResult;
                        req_q.data <= bus.write_data;
                        req_q.size <= bus.mem_size;
                        req_q.sign <= bus.load_signed;
                        req_q.we   <= bus.MemoryWrite;
                        asm_q      <= '0;
                        cnt        <= '0;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (bus.mem_ready) begin
                        if (!req_q.we)
                            asm_q <= {asm_q[23:0], bus.mem_rdata};
                        cnt <= cnt + 3'd1;
                        if (cnt == last_idx)
                            state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    load_extend u_ext (
        .asm_data (asm_q),
        .size     (req_q.size),
        .sign_ext (req_q.sign),
        .load_data(ext_data)
    );
endmodule

// File: tb/tb_load_store_unit.sv
// Randomised and directed checks of load_store_unit against a byte-array memory model.
module tb_load_store_unit;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_W(32)) bus ();
    load_store_unit #(.ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;

    logic [7:0] tbmem [256];
    logic [7:0] rd_q [$];
    logic [7:0] wa_q [$];
    logic [7:0] wd_q [$];
    int          done_cyc, lv_total, fault_cnt, lows, unstable;
    bit          lv_at_done, memreq_seen, stall0, reaccept, timeout;
    logic [31:0] ld_at_done;

    task automatic clear_inputs();
        bus.MemoryRead  = 1'b0;
        bus.MemoryWrite = 1'b0;
        bus.ALUResult   = '0;
        bus.write_data  = '0;
        bus.mem_size    = 2'b00;
        bus.load_signed = 1'b0;
    endtask

    // Reference: bytes addr..addr+n-1 read big-endian, then extended by arithmetic.
    function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [1:0] sz, input bit sg);
        logic [31:0] v;
        int n;
        v = 0;
        n = 1 << sz;
        for (int i = 0; i < n; i++) v = (v << 8) + 32'(tbmem[8'(a + 32'(i))]);
        if (sg && n == 1 && v >= 128) v = v + 32'hFFFF_FF00;
        if (sg && n == 2 && v >= 32768) v = v + 32'hFFFF_0000;
        return v;
    endfunction

    // Acts as pipeline and memory for one request; records what the DUT did.
    task automatic do_op(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] sz, input logic sg, input int hold_byte, input int hold_n,
                         input bit rnd);
        int nb, holds;
        bit pend, fin, stall_prev, lo;
        logic [31:0] paddr;
        logic pwe;
        logic [7:0] pwd;
        rd_q.delete(); wa_q.delete(); wd_q.delete();
        done_cyc = -1; lv_total = 0; fault_cnt = 0; lows = 0; unstable = 0;
        lv_at_done = 0; memreq_seen = 0; stall0 = 0; reaccept = 0; timeout = 0; ld_at_done = '0;
        nb = 0; holds = hold_n; pend = 0; fin = 0; stall_prev = 0;
        paddr = '0; pwe = 0; pwd = '0;
        for (int k = 0; k < 60 && !fin; k++) begin
            @(negedge clk);
            if (k == 0) begin
                bus.MemoryRead = rd; bus.MemoryWrite = wr; bus.ALUResult = addr;
                bus.write_data = wd; bus.mem_size = sz; bus.load_signed = sg;
            end else if (!stall_prev) begin
                clear_inputs();
            end
            #1;
            stall_prev = bus.stall;
            if (k == 0) stall0 = bus.stall;
            if (bus.fault) fault_cnt++;
            if (bus.load_valid) lv_total++;
            if (bus.mem_req) begin
                memreq_seen = 1;
                if (done_cyc >= 0) reaccept = 1;
                if (pend && (bus.mem_addr !== paddr || bus.mem_we !== pwe || bus.mem_wdata !== pwd)) unstable++;
                paddr = bus.mem_addr; pwe = bus.mem_we; pwd = bus.mem_wdata;
                lo = rnd ? ($urandom_range(0, 2) == 0) : (nb == hold_byte && holds > 0);
                if (lo) begin
                    bus.mem_ready = 1'b0;
                    bus.mem_rdata = 8'($urandom);
                    pend = 1; lows++;
                    if (!rnd) holds--;
                end else begin
                    bus.mem_ready = 1'b1;
                    pend = 0;
                    if (bus.mem_we) begin
                        tbmem[bus.mem_addr[7:0]] = bus.mem_wdata;
                        wa_q.push_back(bus.mem_addr[7:0]);
                        wd_q.push_back(bus.mem_wdata);
                    end else begin
                        bus.mem_rdata = tbmem[bus.mem_addr[7:0]];
                        rd_q.push_back(bus.mem_addr[7:0]);
                    end
                    nb++;
                end
            end else begin
                // memory noise while no request is outstanding must be ignored
                bus.mem_ready = 1'($urandom_range(0, 1));
                bus.mem_rdata = 8'($urandom);
                if (k > 0 && memreq_seen && done_cyc < 0) begin
                    done_cyc = k; lv_at_done = bus.load_valid; ld_at_done = bus.load_data;
                end
            end
            if (done_cyc >= 0 && k == done_cyc + 1) fin = 1;
            if (!stall0 && !memreq_seen && k >= 3) fin = 1;
        end
        if (!fin) timeout = 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", bus.mem_req); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b want 0", bus.mem_we); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", bus.stall); end
        checks++; if (bus.load_valid !== 1'b0) begin errors++; $display("FAIL reset_load_valid got %b want 0", bus.load_valid); end
        checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", bus.fault); end
        checks++; if (bus.load_data !== 32'h0) begin errors++; $display("FAIL reset_load_data got %h want 0", bus.load_data); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_word_load();
        tbmem[8'h10] = 8'h12; tbmem[8'h11] = 8'h34; tbmem[8'h12] = 8'h56; tbmem[8'h13] = 8'h78;
        do_op(1'b1, 1'b0, 32'h10, 32'h0, SZ_WORD, 1'b0, 0, 0, 1'b0);
        checks++; if (timeout) begin errors++; $display("FAIL word_timeout got timeout want done"); end
        checks++; if (stall0 !== 1'b1) begin errors++; $display("FAIL word_stall got %b want 1", stall0); end
        checks++; if (done_cyc != 5) begin errors++; $display("FAIL word_latency got %0d want 5", done_cyc); end
        checks++; if (lv_at_done !== 1'b1) begin errors++; $display("FAIL word_valid got %b want 1", lv_at_done); end
        checks++; if (ld_at_done !== 32'h1234_5678) begin errors++; $display("FAIL word_data got %h want 12345678", ld_at_done); end
        checks++; if (lv_total != 1) begin errors++; $display("FAIL word_valid_pulse got %0d want 1", lv_total); end
        checks++; if (reaccept) begin errors++; $display("FAIL word_reaccept got 1 want 0"); end
        checks++; if (rd_q.size() != 4) begin errors++; $display("FAIL word_nreads got %0d want 4", rd_q.size()); end
        for (int i = 0; i < rd_q.size(); i++) begin
            checks++; if (rd_q[i] !== 8'(8'h10 + i)) begin errors++; $display("FAIL word_addr%0d got %h want %h", i, rd_q[i], 8'(8'h10 + i)); end
        end
    endtask

    task automatic test_byte_sign();
        tbmem[8'h13] = 8'h80;
        do_op(1'b1, 1'b0, 32'h13, 32'h0, SZ_BYTE, 1'b1, 0, 0, 1'b0);
        checks++; if (ld_at_done !== 32'hFFFF_FF80) begin errors++; $display("FAIL byte_signed got %h want ffffff80", ld_at_done); end
        checks++; if (done_cyc != 2) begin errors++; $display("FAIL byte_latency got %0d want 2", done_cyc); end
        do_op(1'b1, 1'b0, 32'h13, 32'h0, SZ_BYTE, 1'b0, 0, 0, 1'b0);
        checks++; if (ld_at_done !== 32'h0000_0080) begin errors++; $display("FAIL byte_unsigned got %h want 00000080", ld_at_done); end
        tbmem[8'h14] = 8'h9A; tbmem[8'h15] = 8'hBC;
        do_op(1'b1, 1'b0, 32'h14, 32'h0, SZ_HALF, 1'b1, 0, 0, 1'b0);
        checks++; if (ld_at_done !== 32'hFFFF_9ABC) begin errors++; $display("FAIL half_signed got %h want ffff9abc", ld_at_done); end
        tbmem[8'h13] = 8'h78;
    endtask

    task automatic test_half_store();
        tbmem[8'h20] = 8'h00; tbmem[8'h21] = 8'h00;
        do_op(1'b0, 1'b1, 32'h20, 32'h0000_ABCD, SZ_HALF, 1'b0, 0, 0, 1'b0);
        checks++; if (wa_q.size() != 2) begin errors++; $display("FAIL hst_nwrites got %0d want 2", wa_q.size()); end
        checks++; if (tbmem[8'h20] !== 8'hAB) begin errors++; $display("FAIL hst_byte0 got %h want ab", tbmem[8'h20]); end
        checks++; if (tbmem[8'h21] !== 8'hCD) begin errors++; $display("FAIL hst_byte1 got %h want cd", tbmem[8'h21]); end
        checks++; if (wa_q.size() > 0 && wa_q[0] !== 8'h20) begin errors++; $display("FAIL hst_order got %h want 20", wa_q[0]); end
        checks++; if (lv_total != 0) begin errors++; $display("FAIL hst_load_valid got %0d want 0", lv_total); end
        checks++; if (done_cyc != 3) begin errors++; $display("FAIL hst_latency got %0d want 3", done_cyc); end
    endtask

    task automatic test_faults();
        logic [31:0] ad [4] = '{32'h12, 32'h10, 32'h10, 32'h21};
        logic [1:0]  sz [4] = '{SZ_WORD, SZ_WORD, SZ_RSVD, SZ_HALF};
        logic        wr [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            do_op(1'b1, wr[i], ad[i], 32'h0, sz[i], 1'b0, 0, 0, 1'b0);
            checks++; if (fault_cnt != 1) begin errors++; $display("FAIL fault%0d_pulses got %0d want 1", i, fault_cnt); end
            checks++; if (memreq_seen) begin errors++; $display("FAIL fault%0d_mem_req got 1 want 0", i); end
            checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL fault%0d_stall got %b want 0", i, stall0); end
        end
    endtask

    task automatic test_ready_hold();
        do_op(1'b1, 1'b0, 32'h10, 32'h0, SZ_WORD, 1'b0, 1, 3, 1'b0);
        checks++; if (done_cyc != 8) begin errors++; $display("FAIL hold_latency got %0d want 8", done_cyc); end
        checks++; if (unstable != 0) begin errors++; $display("FAIL hold_stable got %0d changes want 0", unstable); end
        checks++; if (ld_at_done !== 32'h1234_5678) begin errors++; $display("FAIL hold_data got %h want 12345678", ld_at_done); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.mem_ready = 1'b0;
        bus.MemoryRead = 1'b1; bus.ALUResult = 32'h10; bus.mem_size = SZ_WORD; bus.load_signed = 1'b0;
        @(negedge clk); #1;
        checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL rstmid_access got %b want 1", bus.mem_req); end
        @(negedge clk); #1;
        #1 rst = 1'b1;
        clear_inputs();
        #1;
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rstmid_mem_req got %b want 0", bus.mem_req); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall got %b want 0", bus.stall); end
        checks++; if (bus.load_data !== 32'h0) begin errors++; $display("FAIL rstmid_load_data got %h want 0", bus.load_data); end
        @(negedge clk);
        rst = 1'b0;
        do_op(1'b1, 1'b0, 32'h10, 32'h0, SZ_WORD, 1'b0, 0, 0, 1'b0);
        checks++; if (ld_at_done !== 32'h1234_5678 || done_cyc != 5) begin
            errors++; $display("FAIL rstmid_after got %h/%0d want 12345678/5", ld_at_done, done_cyc);
        end
    endtask

    task automatic test_random();
        logic rd, wr, sg;
        logic [1:0] sz;
        logic [31:0] addr, wd, exp;
        int n, kind;
        bit valid;
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 9);
            rd = kind <= 4 || kind == 9;
            wr = (kind >= 5 && kind <= 8) || kind == 9;
            sz = ($urandom_range(0, 7) == 0) ? SZ_RSVD : 2'($urandom_range(0, 2));
            addr = $urandom_range(0, 255);
            if (sz != SZ_RSVD && $urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << sz) - 1);
            wd = $urandom;
            sg = 1'($urandom_range(0, 1));
            n = 1 << sz;
            valid = (rd != wr) && sz != SZ_RSVD && (addr % n == 0);
            exp = valid ? exp_load(addr, sz, sg) : 32'h0;
            do_op(rd, wr, addr, wd, sz, sg, 0, 0, 1'b1);
            checks++; if (timeout) begin errors++; $display("FAIL rnd%0d_timeout got timeout want done", t); end
            if (valid) begin
                checks++; if (done_cyc != n + 1 + lows) begin errors++; $display("FAIL rnd%0d_latency got %0d want %0d", t, done_cyc, n + 1 + lows); end
                checks++; if (unstable != 0 || fault_cnt != 0 || reaccept) begin
                    errors++; $display("FAIL rnd%0d_ctrl got unstable=%0d fault=%0d reaccept=%0d want 0/0/0", t, unstable, fault_cnt, reaccept);
                end
                if (rd) begin
                    checks++; if (ld_at_done !== exp || lv_total != 1) begin
                        errors++; $display("FAIL rnd%0d_load got %h x%0d want %h x1", t, ld_at_done, lv_total, exp);
                    end
                end else begin
                    checks++; if (wa_q.size() != n || lv_total != 0) begin
                        errors++; $display("FAIL rnd%0d_store got %0d writes lv=%0d want %0d lv=0", t, wa_q.size(), lv_total, n);
                    end
                    for (int i = 0; i < wa_q.size() && i < n; i++) begin
                        checks++; if (wa_q[i] !== 8'(addr + 32'(i)) || wd_q[i] !== 8'(wd >> (8 * (n - 1 - i)))) begin
                            errors++; $display("FAIL rnd%0d_wbyte%0d got %h@%h want %h@%h", t, i, wd_q[i], wa_q[i], 8'(wd >> (8 * (n - 1 - i))), 8'(addr + 32'(i)));
                        end
                    end
                end
            end else begin
                checks++; if (fault_cnt != ((rd | wr) ? 1 : 0) || memreq_seen || stall0) begin
                    errors++; $display("FAIL rnd%0d_reject got fault=%0d req=%0d stall=%0d want %0d/0/0", t, fault_cnt, memreq_seen, stall0, (rd | wr) ? 1 : 0);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) tbmem[i] = 8'($urandom);
        test_reset();
        test_word_load();
        test_byte_sign();
        test_half_store();
        test_faults();
        test_ready_hold();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
